// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// The optional borrow-in port is controlled by SERIAL_SUB_BORROW_IN_EN.
package serial_sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit-counter width; floored at 1 so the counter always exists.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Defining SERIAL_SUB_BORROW_IN_EN adds a borrow-in port sampled with start.
//
// state | meaning
// IDLE  | waiting for start; diff/borrow hold the last result
// RUN   | shifting one bit per clock through the full subtractor
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_SUB_BORROW_IN_EN
  input  logic             bin,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-2:0]   r_sr;
  logic [WIDTH-1:0]   res_next;
  logic [CNT_W-1:0]   cnt;
  logic               br;
  logic               br_seed;
  logic               d_bit;
  logic               bout_bit;
  logic               last_bit;

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign br_seed = bin;
`else
  assign br_seed = 1'b0;
`endif

  full_subtractor u_fsub (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // Newest bit enters at the MSB; on the last bit this is the full result.
  assign res_next = {d_bit, r_sr};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          a_sr <= a;
          b_sr <= b;
          br   <= br_seed;
          cnt  <= '0;
        end
      end else begin
        a_sr <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr <= {1'b0, b_sr[WIDTH-1:1]};
        r_sr <= res_next[WIDTH-1:1];
        br   <= bout_bit;
        if (last_bit) begin
          cnt    <= '0;
          diff   <= res_next;
          borrow <= bout_bit;
          done   <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit unsigned subtractor: computes diff = a - b, LSB first, one bit per clock, using a single full-subtractor cell and a registered borrow.
- It is the inverse-operation companion to the team's combinational full adder.
- Used where area matters more than latency; start/done handshake toward a controlling FSM.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; a, b sampled on the same edge when accepted.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse: diff/borrow updated.
- diff  output  WIDTH  result a - b modulo 2^WIDTH.
- borrow  output  1  final borrow-out; 1 iff a < b (unsigned, plus borrow-in when enabled).

Behaviour:
- Reset (rst sampled high at a rising edge): state IDLE, busy=0, done=0, diff=0, borrow=0, bit counter=0, internal shift/borrow registers=0.
- States: IDLE, RUN.
- IDLE -> RUN: on an edge with start=1.
  - Load a_sr<=a, b_sr<=b, br<=0, cnt<=0.
  - busy becomes 1 next cycle.
- RUN, each edge:
  - d = a_sr[0]^b_sr[0]^br
  - bout = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&br)
  - Shift a_sr and b_sr right one bit; shift d into the MSB of result shift register r_sr; br<=bout; cnt<=cnt+1.
- RUN -> IDLE: on the edge processing bit WIDTH-1 (cnt==WIDTH-1). The same edge writes diff<={d, r_sr[WIDTH-1:1]}, borrow<=bout, done<=1, busy<=0.
- Latency: start sampled at edge k; done/diff/borrow valid in the cycle after edge k+WIDTH.
- done is high exactly one cycle. diff/borrow hold their value until the next completion or reset. They never show partial results while busy.
- start while busy=1: ignored; operands not resampled.
- start in the cycle done=1: accepted (state is IDLE), enabling back-to-back operation with no gap cycle.
- a/b changes while busy: no effect.
- Reset mid-RUN: aborts. No done pulse; outputs go to reset values; next start works normally.
- cnt width: $clog2(WIDTH); no wrap beyond WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUB_BORROW_IN_EN.
- Defined:
  - Adds port bin (input, 1), sampled with start.
  - Seeds br<=bin, so result = a - b - bin. borrow reflects the full chain.
  - Enables cascading multi-word subtraction.
- Undefined: port absent; br seeded with 0.

Decomposition:
- Package serial_sub_pkg:
  - state encoding constants (IDLE=1'b0, RUN=1'b1)
  - localparam CNT_W = $clog2(WIDTH) helper.
- Sub-module full_subtractor: combinational (a, b, bin -> d, bout).
  - Instantiated once.
  - Separately unit-testable with an exhaustive 8-vector bench.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h23, start 1 cycle -> busy 8 cycles; done pulse in the cycle after the 8th edge; diff=8'h37, borrow=0.
- a=8'h10, b=8'h20 -> diff=8'hF0, borrow=1. a=8'h00, b=8'hFF -> diff=8'h01, borrow=1. a=b=8'hFF -> diff=8'h00, borrow=0.
- Second start pulse at cycle 3 of a run with different operands -> ignored; result matches first operands. Start asserted in the done cycle -> second result 8 cycles later, zero idle gap.
- rst high at RUN cycle 4 -> next cycle busy=0, diff=0, borrow=0; no done ever fires. Fresh start a=8'h05, b=8'h03 -> diff=8'h02.
- Hold-check: after done, change a/b and idle 20 cycles -> diff/borrow unchanged, done stays 0.
- With SERIAL_SUB_BORROW_IN_EN: a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, borrow=1. a=8'h05, b=8'h03, bin=1 -> diff=8'h01, borrow=0.
